// File: rtl/sequential_counter_modes.sv
// ============================================================================
// Module   : sequential_counter_modes
// Brief    : Up/down counter with prescaler, debounced step button and sticky
//            wrap flag on 24-pin user I/O. COUNTER_SATURATE_EN selects
//            saturating instead of modulo counting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequential_counter_modes #(
  parameter int COUNTER_WIDTH   = 32,
  parameter int OUT_TAP         = 28,
  parameter int PRESCALE_BITS   = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic [23:0] io_in,
  output logic [23:0] io_out,
  output logic [23:0] io_oeb
);

  localparam int c_deb_w = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_deb_w-1:0] c_deb_one  = c_deb_w'(1);
  localparam logic [COUNTER_WIDTH-1:0] c_ctr_one = COUNTER_WIDTH'(1);

  logic rst;
  assign rst = io_in[23];

  // {enable, direction, button} two-flop synchronisers
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic       r_en_s;
  logic       r_dir_s;
  logic       r_btn_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {io_in[22], io_in[11], io_in[10]};
      r_sync2 <= r_sync1;
    end
  end

  assign r_en_s  = r_sync2[2];
  assign r_dir_s = r_sync2[1];
  assign r_btn_s = r_sync2[0];

  logic w_tick;

  generate
    if (PRESCALE_BITS == 0) begin : g_no_prescale
      assign w_tick = 1'b1;
    end else begin : g_prescale
      localparam logic [PRESCALE_BITS-1:0] c_pre_one = PRESCALE_BITS'(1);
      logic [PRESCALE_BITS-1:0] r_pre;
      always_ff @(posedge clk) begin
        if (rst) r_pre <= '0;
        else     r_pre <= r_pre + c_pre_one;
      end
      assign w_tick = &r_pre;
    end
  endgenerate

  logic               r_deb;
  logic               r_deb_d;
  logic [c_deb_w-1:0] r_deb_cnt;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing edges
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb     <= 1'b0;
      r_deb_d   <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_deb_d <= r_deb;
      if (r_btn_s == r_deb) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == c_deb_last) begin
        r_deb     <= r_btn_s;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + c_deb_one;
      end
    end
  end

  logic w_step;
  logic w_adv;
  assign w_step = r_deb & ~r_deb_d;
  assign w_adv  = r_en_s ? w_tick : w_step;

  logic [COUNTER_WIDTH-1:0] r_ctr;
  logic                     r_wrap;
  logic [COUNTER_WIDTH-1:0] w_ctr_next;
  logic                     w_at_limit;

  always_comb begin
    w_ctr_next = r_dir_s ? (r_ctr - c_ctr_one) : (r_ctr + c_ctr_one);
    w_at_limit = r_dir_s ? ~|r_ctr : &r_ctr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctr  <= '0;
      r_wrap <= 1'b0;
    end else if (w_adv) begin
      if (w_at_limit) r_wrap <= 1'b1;
`ifdef COUNTER_SATURATE_EN
      if (!w_at_limit) r_ctr <= w_ctr_next;
`else
      r_ctr <= w_ctr_next;
`endif
    end
  end

  assign io_out = {2'b00, r_ctr[OUT_TAP -: 10], 2'b00, r_wrap, r_dir_s, r_ctr[7:0]};
  assign io_oeb = 24'h3FF3FF;

  logic w_unused_pins;
  assign w_unused_pins = ^{io_in[21:12], io_in[9:0]};

endmodule

`default_nettype wire

// File: tb/tb_sequential_counter_modes.sv
// ============================================================================
// Module   : tb_sequential_counter_modes
// Brief    : Randomised and directed checks of two sequential_counter_modes
//            instances against a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sequential_counter_modes;

  localparam int A_W = 32, A_TAP = 28, A_P = 0, A_D = 16;
  localparam int B_W = 12, B_TAP = 11, B_P = 4, B_D = 3;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic [23:0] io_in = '0;
  logic [23:0] out_a, oeb_a, out_b, oeb_b;

  always #5 clk = ~clk;

  sequential_counter_modes #(.COUNTER_WIDTH(A_W), .OUT_TAP(A_TAP),
                             .PRESCALE_BITS(A_P), .DEBOUNCE_CYCLES(A_D)) dut_a (
    .clk(clk), .io_in(io_in), .io_out(out_a), .io_oeb(oeb_a));

  sequential_counter_modes #(.COUNTER_WIDTH(B_W), .OUT_TAP(B_TAP),
                             .PRESCALE_BITS(B_P), .DEBOUNCE_CYCLES(B_D)) dut_b (
    .clk(clk), .io_in(io_in), .io_out(out_b), .io_oeb(oeb_b));

  typedef struct packed {
    bit en1, en_s, dir1, dir_s, btn1, btn_s, deb, deb_prev, wrap;
    int run;
    longint unsigned ctr;
    longint unsigned ncyc;
  } m_state_t;

  m_state_t ma, mb;
  bit       m_valid = 1'b0;
  int       n_vec = 0;
  int       n_err = 0;

  // One clock edge of the specified behaviour, from the pin values at that edge
  function automatic m_state_t model_step(m_state_t s, logic [23:0] p, int w, int pb, int d);
    m_state_t n;
    longint unsigned per, mx;
    bit tick, step, adv;
    n = s;
    if (p[23]) begin
      n = '0;
      return n;
    end
    per  = 64'd1 << pb;
    mx   = (64'd1 << w) - 64'd1;
    tick = (s.ncyc % per) == (per - 64'd1);
    step = s.deb && !s.deb_prev;
    adv  = s.en_s ? tick : step;
    if (adv) begin
      if (!s.dir_s) begin
        if (s.ctr == mx) begin n.wrap = 1'b1; n.ctr = SAT ? mx : 64'd0; end
        else n.ctr = s.ctr + 64'd1;
      end else begin
        if (s.ctr == 64'd0) begin n.wrap = 1'b1; n.ctr = SAT ? 64'd0 : mx; end
        else n.ctr = s.ctr - 64'd1;
      end
    end
    if (s.btn_s == s.deb) n.run = 0;
    else if (s.run + 1 == d) begin n.deb = s.btn_s; n.run = 0; end
    else n.run = s.run + 1;
    n.deb_prev = s.deb;
    n.en1 = p[22]; n.en_s = s.en1;
    n.dir1 = p[11]; n.dir_s = s.dir1;
    n.btn1 = p[10]; n.btn_s = s.btn1;
    n.ncyc = s.ncyc + 64'd1;
    return n;
  endfunction

  function automatic logic [23:0] model_out(m_state_t s, int tap);
    logic [23:0] o;
    longint unsigned top;
    o = '0;
    top = (s.ctr >> (tap - 9)) & 64'h3FF;
    o[21:12] = top[9:0];
    o[9] = s.wrap;
    o[8] = s.dir_s;
    o[7:0] = s.ctr[7:0];
    return o;
  endfunction

  function automatic logic [23:0] mk(bit r, bit e, bit dr, bit b);
    logic [23:0] v;
    v = 24'($urandom);
    v[23] = r; v[22] = e; v[11] = dr; v[10] = b;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic [23:0] p);
    io_in = p;
    @(posedge clk);
    if (p[23]) m_valid = 1'b1;
    if (m_valid) begin
      ma = model_step(ma, p, A_W, A_P, A_D);
      mb = model_step(mb, p, B_W, B_P, B_D);
    end
    @(negedge clk);
    if (m_valid) begin
      check("model_a", {8'h0, out_a}, {8'h0, model_out(ma, A_TAP)});
      check("model_b", {8'h0, out_b}, {8'h0, model_out(mb, B_TAP)});
    end
  endtask

  task automatic do_reset();
    cycle(mk(1, 0, 0, 0));
    cycle(mk(1, 0, 0, 0));
  endtask

  initial begin
    bit r, e, dr, b;
    ma = '0;
    mb = '0;
    @(negedge clk);

    // Reset held with random other inputs
    repeat (3) begin
      cycle(mk(1'b1, 1'($urandom), 1'($urandom), 1'($urandom)));
      check("rst_out_a", {8'h0, out_a}, 32'h0);
      check("rst_out_b", {8'h0, out_b}, 32'h0);
      check("rst_oeb_a", {8'h0, oeb_a}, 32'h3FF3FF);
      check("rst_oeb_b", {8'h0, oeb_b}, 32'h3FF3FF);
    end
    cycle(mk(0, 1, 1, 1));
    check("post_rst_a", {8'h0, out_a}, 32'h0);
    check("post_rst_b", {8'h0, out_b}, 32'h0);

    // Up count: ctr reaches 300 after 302 edges from the enable edge
    do_reset();
    repeat (302) cycle(mk(0, 1, 0, 0));
    check("up_lo", {24'h0, out_a[7:0]}, 32'h2C);
    check("up_wrap", {31'h0, out_a[9]}, 32'h0);
    check("up_dir", {31'h0, out_a[8]}, 32'h0);

    // Down from zero, enable pin high for a single edge
    do_reset();
    cycle(mk(0, 1, 1, 0));
    repeat (5) cycle(mk(0, 0, 1, 0));
`ifdef COUNTER_SATURATE_EN
    check("dn_lo", {24'h0, out_a[7:0]}, 32'h00);
    check("dn_hi", {22'h0, out_a[21:12]}, 32'h000);
`else
    check("dn_lo", {24'h0, out_a[7:0]}, 32'hFF);
    check("dn_hi", {22'h0, out_a[21:12]}, 32'h3FF);
`endif
    check("dn_wrap", {31'h0, out_a[9]}, 32'h1);

    // Prescaler: 160 synchronised enable cycles give 10 advances
    do_reset();
    repeat (162) cycle(mk(0, 1, 0, 0));
    check("presc_lo", {24'h0, out_b[7:0]}, 32'h0A);

    // Bounce rejection on the 16-cycle debouncer
    do_reset();
    for (int i = 0; i < 200; i++) cycle(mk(0, 0, 0, ((i / 10) % 2) == 0));
    check("bounce_none", {24'h0, out_a[7:0]}, 32'h00);
    repeat (48) cycle(mk(0, 0, 0, 1));
    check("bounce_one", {24'h0, out_a[7:0]}, 32'h01);

    // Mid-operation reset with wrap set and the debouncer mid-count
    do_reset();
    cycle(mk(0, 1, 1, 0));
    repeat (3) cycle(mk(0, 0, 1, 0));
    repeat (6) cycle(mk(0, 1, 0, 0));
    repeat (8) cycle(mk(0, 1, 0, 1));
    cycle(mk(1, 1, 0, 1));
    check("mid_rst_a", {8'h0, out_a}, 32'h0);
    check("mid_rst_b", {8'h0, out_b}, 32'h0);
    cycle(mk(0, 1, 0, 1));
    check("resume_1", {24'h0, out_a[7:0]}, 32'h00);
    cycle(mk(0, 1, 0, 1));
    check("resume_2", {24'h0, out_a[7:0]}, 32'h00);
    cycle(mk(0, 1, 0, 1));
    check("resume_3", {24'h0, out_a[7:0]}, 32'h01);

    // Randomised operation
    r = 0; e = 0; dr = 0; b = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) e = ~e;
      if ($urandom_range(0, 29) == 0) dr = ~dr;
      if ($urandom_range(0, 7) == 0) b = ~b;
      cycle(mk(r, e, dr, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
